// File: rtl/alu_pkg.sv
// Shared constants for the ALU multiply/divide/negate path:
// op field encodings, op bit positions and the sequencer state encoding.
package alu_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam int OPB_SIGNED = 1;
  localparam int OPB_W16    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/c2_negate.sv
// Two's-complement negation with bypass; used for both operands and the results.
module c2_negate #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = en_i ? (~x_i + WIDTH'(1)) : x_i;

endmodule

// File: rtl/seq_muldiv_core.sv
// Iterative sign-magnitude multiply / restoring divide / negate unit.
// Operands are made positive, an unsigned loop runs, then the result takes its sign back.
module seq_muldiv_core
  import alu_pkg::*;
#(
  parameter int W    = 16,
  parameter int CNTW = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  input  logic         c2inA,
  input  logic         c2inB,
  input  logic         c2out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result_lo,
  output logic [W-1:0] result_hi,
  output logic         dz,
  output logic         ovf
);

  localparam int H = W / 2;

  state_e          state_q, state_d;
  logic [1:0]      kind_q;
  logic            w16_q;
  logic [W-1:0]    a_q, b_q, d_q;
  logic            c2a_q, c2b_q, c2o_q;
  logic [2*W-1:0]  acc_q, mcand_q;
  logic [W-1:0]    opb_q, rem_q, dlo_q, quot_q;
  logic [CNTW-1:0] cnt_q;
  logic [W-1:0]    res_lo_q, res_hi_q;
  logic            dz_q, ovf_q;

  // Sign handling is fully described by the c2 controls; the signed bit is informational.
  logic unused_signed;
  assign unused_signed = op[OPB_SIGNED];

  logic            accept;
  logic [W-1:0]    mask_n;
  logic [2*W-1:0]  mask_2n;
  logic [CNTW-1:0] cnt_last;

  assign accept   = (state_q == ST_IDLE) && start;
  assign mask_n   = w16_q ? {W{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
  assign mask_2n  = w16_q ? {(2*W){1'b1}} : {{W{1'b0}}, {W{1'b1}}};
  assign cnt_last = w16_q ? CNTW'(W - 1) : CNTW'(H - 1);

  logic [2*W-1:0] a_src, a_neg, dvd;
  logic [W-1:0]   b_neg, b_mag, a_mag, dvd_hi, dvd_lo;
  logic           div_by_zero;

  assign a_src = (kind_q == OP_DIV && w16_q) ? {d_q, a_q} : {{W{1'b0}}, a_q};

  c2_negate #(.WIDTH(2*W)) u_neg_a (.x_i(a_src), .en_i(c2a_q), .y_o(a_neg));
  c2_negate #(.WIDTH(W))   u_neg_b (.x_i(b_q),   .en_i(c2b_q), .y_o(b_neg));

  assign b_mag       = b_neg & mask_n;
  assign a_mag       = a_neg[W-1:0] & mask_n;
  assign dvd         = a_neg & mask_2n;
  assign dvd_hi      = w16_q ? dvd[2*W-1:W] : {{H{1'b0}}, dvd[W-1:H]};
  // The low dividend half is left-aligned so the loop always shifts out bit W-1.
  assign dvd_lo      = w16_q ? dvd[W-1:0] : {dvd[H-1:0], {H{1'b0}}};
  assign div_by_zero = (b_mag == '0);

  logic [W:0]   trial;
  logic [W-1:0] diff;
  logic         qbit;

  assign trial = {rem_q, dlo_q[W-1]};
  assign qbit  = (trial >= {1'b0, opb_q});
  assign diff  = trial[W-1:0] - opb_q;

  logic [2*W-1:0] fix_src, fix_neg, prod;
  logic [W-1:0]   rem_neg;

  assign fix_src = (kind_q == OP_MUL) ? acc_q : {{W{1'b0}}, quot_q};

  c2_negate #(.WIDTH(2*W)) u_neg_res (.x_i(fix_src), .en_i(c2o_q), .y_o(fix_neg));
  c2_negate #(.WIDTH(W))   u_neg_rem (.x_i(rem_q),   .en_i(c2a_q), .y_o(rem_neg));

  assign prod = fix_neg & mask_2n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Short operations still pass through FIX so every result is written from one place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PREP;
      ST_PREP: state_d = (kind_q == OP_MUL || (kind_q == OP_DIV && !div_by_zero))
                         ? ST_RUN : ST_FIX;
      ST_RUN:  if (cnt_q == cnt_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q   <= '0;
      w16_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      c2a_q    <= 1'b0;
      c2b_q    <= 1'b0;
      c2o_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      dlo_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        kind_q <= op[3:2];
        w16_q  <= op[OPB_W16];
        a_q    <= a;
        b_q    <= b;
        d_q    <= d;
        c2a_q  <= c2inA;
        c2b_q  <= c2inB;
        c2o_q  <= c2out;
        dz_q   <= 1'b0;
        ovf_q  <= 1'b0;
      end
      case (state_q)
        ST_PREP: begin
          acc_q   <= (kind_q == OP_NEG) ? {{W{1'b0}}, a_mag} : '0;
          mcand_q <= {{W{1'b0}}, a_mag};
          opb_q   <= b_mag;
          rem_q   <= dvd_hi;
          dlo_q   <= dvd_lo;
          quot_q  <= '0;
          cnt_q   <= '0;
          if (kind_q == OP_DIV) begin
            dz_q  <= div_by_zero;
            ovf_q <= !div_by_zero && (dvd_hi >= b_mag);
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + CNTW'(1);
          if (kind_q == OP_MUL) begin
            if (opb_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            opb_q   <= opb_q >> 1;
          end else begin
            rem_q  <= qbit ? diff : trial[W-1:0];
            dlo_q  <= dlo_q << 1;
            quot_q <= {quot_q[W-2:0], qbit};
          end
        end
        ST_FIX: begin
          case (kind_q)
            OP_MUL: begin
              res_lo_q <= prod[W-1:0];
              res_hi_q <= prod[2*W-1:W];
            end
            OP_DIV: begin
              res_lo_q <= dz_q ? mask_n : (fix_neg[W-1:0] & mask_n);
              res_hi_q <= dz_q ? mask_n : (rem_neg & mask_n);
            end
            OP_NEG: begin
              res_lo_q <= acc_q[W-1:0];
              res_hi_q <= '0;
            end
            default: begin
              res_lo_q <= '0;
              res_hi_q <= '0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done      = (state_q == ST_DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_muldiv_core.sv
// Randomised and directed bench for seq_muldiv_core against an arithmetic reference model.
module tb_seq_muldiv_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [15:0] a = 16'h0, b = 16'h0, d = 16'h0;
  logic        c2inA = 1'b0, c2inB = 1'b0, c2out = 1'b0;
  logic        busy, done, dz, ovf;
  logic [15:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_muldiv_core #(.W(16), .CNTW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .d(d),
    .c2inA(c2inA), .c2inB(c2inB), .c2out(c2out),
    .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi),
    .dz(dz), .ovf(ovf)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, d;
    logic        c2a, c2b, c2o;
    logic [15:0] lo, hi;
    logic        dz;
    int          lat;
  } dvec_t;

  // Reference: plain integer arithmetic on magnitudes, signs applied afterwards.
  task automatic model(input logic [3:0] mop, input logic [15:0] ma, mb, md,
                       input logic mc2a, mc2b, mc2o,
                       output logic [15:0] elo, ehi, output logic edz, eovf,
                       output int elat, output bit eres);
    int n;
    longint unsigned mn, m2n, aa, bb, dv, p, q, r;
    n    = mop[0] ? 16 : 8;
    mn   = (64'd1 << n) - 64'd1;
    m2n  = (64'd1 << (2 * n)) - 64'd1;
    elo  = '0; ehi = '0; edz = 1'b0; eovf = 1'b0; elat = 3; eres = 1'b1;
    bb   = mc2b ? (64'd0 - 64'(mb)) : 64'(mb);
    bb   = bb & mn;
    case (mop[3:2])
      2'b00: begin
        aa = mc2a ? (64'd0 - 64'(ma)) : 64'(ma);
        aa = aa & mn;
        p  = aa * bb;
        if (mc2o) p = 64'd0 - p;
        p  = p & m2n;
        elo = p[15:0]; ehi = p[31:16]; elat = n + 3;
      end
      2'b01: begin
        dv = mop[0] ? 64'({md, ma}) : 64'(ma);
        if (mc2a) dv = 64'd0 - dv;
        dv = dv & m2n;
        if (bb == 0) begin
          edz = 1'b1; elo = mn[15:0]; ehi = mn[15:0];
        end else begin
          elat = n + 3;
          eovf = ((dv >> n) >= bb);
          q = dv / bb; r = dv % bb;
          if (mc2o) q = 64'd0 - q;
          if (mc2a) r = 64'd0 - r;
          q = q & mn; r = r & mn;
          elo = q[15:0]; ehi = r[15:0];
          if (eovf) eres = 1'b0;
        end
      end
      2'b10: begin
        p = (64'd0 - 64'(ma)) & mn;
        elo = p[15:0];
      end
      default: ;
    endcase
  endtask

  // Launch one operation from IDLE and wait (bounded) for done.
  task automatic do_op(input logic [3:0] top, input logic [15:0] ta, tbv, td,
                       input logic t2a, t2b, t2o,
                       output int lat, output logic [15:0] olo, ohi, output logic odz, oovf);
    @(negedge clk);
    op = top; a = ta; b = tbv; d = td;
    c2inA = t2a; c2inB = t2b; c2out = t2o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    olo = result_lo; ohi = result_hi; odz = dz; oovf = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result_lo !== 16'h0 || result_hi !== 16'h0) begin
      errors++; $display("FAIL reset_results: got %h/%h want 0000/0000", result_hi, result_lo);
    end
    checks++; if (dz !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got dz=%b ovf=%b want 0/0", dz, ovf);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_directed();
    dvec_t dv [5];
    int lat;
    logic [15:0] lo, hi;
    logic zf, of;
    dv[0] = '{4'b0010, 16'h00FD, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFF1, 16'h0000, 1'b0, 11};
    dv[1] = '{4'b0101, 16'h0064, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h000E, 16'h0002, 1'b0, 19};
    dv[2] = '{4'b0111, 16'hFF9C, 16'h0007, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 19};
    dv[3] = '{4'b0101, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 3};
    dv[4] = '{4'b1001, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 3};
    for (int i = 0; i < 5; i++) begin
      do_op(dv[i].op, dv[i].a, dv[i].b, dv[i].d, dv[i].c2a, dv[i].c2b, dv[i].c2o, lat, lo, hi, zf, of);
      $display("directed[%0d] op=%b a=%h b=%h d=%h -> lo=%h hi=%h dz=%b lat=%0d",
               i, dv[i].op, dv[i].a, dv[i].b, dv[i].d, lo, hi, zf, lat);
      checks++; if (lat !== dv[i].lat) begin errors++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, lat, dv[i].lat); end
      checks++; if (lo !== dv[i].lo || hi !== dv[i].hi) begin
        errors++; $display("FAIL dir_result[%0d]: got %h/%h want %h/%h", i, hi, lo, dv[i].hi, dv[i].lo);
      end
      checks++; if (zf !== dv[i].dz) begin errors++; $display("FAIL dir_dz[%0d]: got %b want %b", i, zf, dv[i].dz); end
    end
  endtask

  task automatic test_mul_random();
    logic [3:0] top;
    logic [15:0] ra, rb, rd, lo, hi, elo, ehi;
    logic r2a, r2b, r2o, zf, of, edz, eovf;
    int lat, elat;
    bit eres;
    for (int i = 0; i < 24; i++) begin
      top = {2'b00, 1'($urandom), 1'($urandom)};
      ra = 16'($urandom); rb = 16'($urandom); rd = 16'($urandom);
      r2a = 1'($urandom); r2b = 1'($urandom); r2o = r2a ^ r2b;
      if (i == 0) begin ra = 16'h0080; rb = 16'h0080; r2a = 1'b0; r2b = 1'b0; r2o = 1'b0; top = 4'b0000; end
      if (i == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; r2a = 1'b0; r2b = 1'b0; r2o = 1'b0; top = 4'b0001; end
      model(top, ra, rb, rd, r2a, r2b, r2o, elo, ehi, edz, eovf, elat, eres);
      do_op(top, ra, rb, rd, r2a, r2b, r2o, lat, lo, hi, zf, of);
      $display("mul[%0d] op=%b a=%h b=%h c2=%b%b%b -> hi=%h lo=%h lat=%0d", i, top, ra, rb, r2a, r2b, r2o, hi, lo, lat);
      checks++; if (lat !== elat) begin errors++; $display("FAIL mul_lat[%0d]: got %0d want %0d", i, lat, elat); end
      checks++; if (lo !== elo || hi !== ehi) begin
        errors++; $display("FAIL mul_result[%0d]: got %h/%h want %h/%h", i, hi, lo, ehi, elo);
      end
      checks++; if (zf !== 1'b0 || of !== 1'b0) begin errors++; $display("FAIL mul_flags[%0d]: got dz=%b ovf=%b want 0/0", i, zf, of); end
    end
  endtask

  task automatic test_div_random();
    logic [3:0] top;
    logic [15:0] ra, rb, rd, lo, hi, elo, ehi;
    logic r2a, r2b, r2o, zf, of, edz, eovf;
    int lat, elat, n;
    bit eres;
    longint unsigned mn, m2n, bm, dh, dd, raw, rawb;
    for (int i = 0; i < 28; i++) begin
      top = {2'b01, 1'($urandom), 1'($urandom)};
      n = top[0] ? 16 : 8;
      mn = (64'd1 << n) - 64'd1; m2n = (64'd1 << (2 * n)) - 64'd1;
      r2a = 1'($urandom); r2b = 1'($urandom); r2o = r2a ^ r2b;
      bm = 64'($urandom) & mn;
      if (bm == 0) bm = 1;
      if (i % 7 == 6) dh = (bm == mn) ? mn : bm + (64'($urandom) % (mn - bm + 1));
      else dh = 64'($urandom) % bm;
      dd = (dh << n) | (64'($urandom) & mn);
      raw = r2a ? ((64'd0 - dd) & m2n) : dd;
      rawb = r2b ? ((64'd0 - bm) & mn) : bm;
      if (top[0]) begin ra = raw[15:0]; rd = raw[31:16]; rb = rawb[15:0]; end
      else begin ra = raw[15:0]; rd = 16'($urandom); rb = {8'($urandom), rawb[7:0]}; end
      model(top, ra, rb, rd, r2a, r2b, r2o, elo, ehi, edz, eovf, elat, eres);
      do_op(top, ra, rb, rd, r2a, r2b, r2o, lat, lo, hi, zf, of);
      $display("div[%0d] op=%b d=%h a=%h b=%h c2=%b%b%b -> q=%h r=%h ovf=%b lat=%0d", i, top, rd, ra, rb, r2a, r2b, r2o, lo, hi, of, lat);
      checks++; if (lat !== elat) begin errors++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, elat); end
      checks++; if (zf !== edz || of !== eovf) begin
        errors++; $display("FAIL div_flags[%0d]: got dz=%b ovf=%b want %b/%b", i, zf, of, edz, eovf);
      end
      if (eres) begin
        checks++; if (lo !== elo || hi !== ehi) begin
          errors++; $display("FAIL div_result[%0d]: got q=%h r=%h want q=%h r=%h", i, lo, hi, elo, ehi);
        end
      end
    end
  endtask

  task automatic test_neg_illegal_dz();
    logic [3:0] top;
    logic [15:0] ra, rb, lo, hi, elo, ehi;
    logic zf, of, edz, eovf;
    int lat, elat;
    bit eres;
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (i % 4)
        0: top = {3'b100, 1'($urandom)};
        1: top = {2'b11, 2'($urandom)};
        2: begin top = {2'b01, 1'($urandom), 1'($urandom)}; rb = top[0] ? 16'h0000 : {8'($urandom), 8'h00}; end
        default: begin top = {3'b100, 1'($urandom)}; ra = top[0] ? 16'h8000 : {8'($urandom), 8'h80}; end
      endcase
      model(top, ra, rb, 16'h0, 1'b1, 1'b0, 1'b0, elo, ehi, edz, eovf, elat, eres);
      do_op(top, ra, rb, 16'h0, 1'b1, 1'b0, 1'b0, lat, lo, hi, zf, of);
      $display("short[%0d] op=%b a=%h b=%h -> lo=%h hi=%h dz=%b lat=%0d", i, top, ra, rb, lo, hi, zf, lat);
      checks++; if (lat !== elat) begin errors++; $display("FAIL short_lat[%0d]: got %0d want %0d", i, lat, elat); end
      checks++; if (lo !== elo || hi !== ehi) begin
        errors++; $display("FAIL short_result[%0d]: got %h/%h want %h/%h", i, hi, lo, ehi, elo);
      end
      checks++; if (zf !== edz || of !== 1'b0) begin
        errors++; $display("FAIL short_flags[%0d]: got dz=%b ovf=%b want %b/0", i, zf, of, edz);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    op = 4'b1001; a = 16'h0005; b = 16'h0; d = 16'h0;
    c2inA = 1'b1; c2inB = 1'b0; c2out = 1'b0; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 50) begin @(negedge clk); cyc++; end
    $display("b2b first done at cycle %0d lo=%h", cyc, result_lo);
    checks++; if (cyc !== 3 || result_lo !== 16'hFFFB) begin
      errors++; $display("FAIL b2b_first: got cycle %0d lo=%h want 3 FFFB", cyc, result_lo);
    end
    op = 4'b0000; a = 16'h0003; b = 16'h0007; c2inA = 1'b0;
    @(negedge clk); cyc++;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result_lo !== 16'hFFFB) begin
      errors++; $display("FAIL b2b_idle_gap: got busy=%b done=%b lo=%h want 0 0 FFFB", busy, done, result_lo);
    end
    @(negedge clk); cyc++;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b want 1", busy); end
    while (!done && cyc < 60) begin @(negedge clk); cyc++; end
    $display("b2b second done at cycle %0d lo=%h hi=%h", cyc, result_lo, result_hi);
    checks++; if (cyc !== 15 || result_lo !== 16'h0015 || result_hi !== 16'h0) begin
      errors++; $display("FAIL b2b_second: got cycle %0d %h/%h want 15 0000/0015", cyc, result_hi, result_lo);
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] elo, ehi;
    logic edz, eovf;
    int elat, cyc, extra;
    bit eres;
    model(4'b0001, 16'h1234, 16'h0ABC, 16'h0, 1'b0, 1'b0, 1'b0, elo, ehi, edz, eovf, elat, eres);
    @(negedge clk);
    op = 4'b0001; a = 16'h1234; b = 16'h0ABC; d = 16'h0;
    c2inA = 1'b0; c2inB = 1'b0; c2out = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    repeat (3) begin @(negedge clk); cyc++; end
    op = 4'b1001; a = 16'h4321; c2inA = 1'b1; start = 1'b1;
    @(negedge clk); cyc++; start = 1'b0;
    while (!done && cyc < 60) begin @(negedge clk); cyc++; end
    $display("busy_ignore done at cycle %0d hi=%h lo=%h", cyc, result_hi, result_lo);
    checks++; if (cyc !== elat) begin errors++; $display("FAIL busy_ignore_lat: got %0d want %0d", cyc, elat); end
    checks++; if (result_lo !== elo || result_hi !== ehi) begin
      errors++; $display("FAIL busy_ignore_result: got %h/%h want %h/%h", result_hi, result_lo, ehi, elo);
    end
    extra = 0;
    repeat (4) begin @(negedge clk); if (done || busy) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignore_queued: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_midrun();
    logic [15:0] lo, hi, elo, ehi;
    logic zf, of, edz, eovf;
    int lat, elat;
    bit eres;
    @(negedge clk);
    op = 4'b0101; a = 16'h0064; b = 16'h0007; d = 16'h0;
    c2inA = 1'b0; c2inB = 1'b0; c2out = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    $display("reset mid-run busy=%b lo=%h hi=%h", busy, result_lo, result_hi);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0/0", busy, done);
    end
    checks++; if (result_lo !== 16'h0 || result_hi !== 16'h0 || dz !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL midrst_results: got %h/%h dz=%b ovf=%b want zeros", result_hi, result_lo, dz, ovf);
    end
    @(negedge clk); rst = 1'b0;
    model(4'b0111, 16'hFF9C, 16'hFFF9, 16'hFFFF, 1'b1, 1'b1, 1'b0, elo, ehi, edz, eovf, elat, eres);
    do_op(4'b0111, 16'hFF9C, 16'hFFF9, 16'hFFFF, 1'b1, 1'b1, 1'b0, lat, lo, hi, zf, of);
    $display("after reset div -> q=%h r=%h lat=%0d", lo, hi, lat);
    checks++; if (lat !== elat || lo !== elo || hi !== ehi) begin
      errors++; $display("FAIL midrst_next: got lat=%0d %h/%h want %0d %h/%h", lat, hi, lo, elat, ehi, elo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_random();
    test_div_random();
    test_neg_illegal_dz();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
